gi: RTL and testbench

- Registered carry-lookahead generate/propagate cell for the adder datapath.
- Per-bit generate is G[i] = A[i] AND B[i]; per-bit propagate is P[i] = A[i] XOR B[i].
- Also produces group generate/propagate and lookahead carries for one WIDTH-bit block.
- Feeds the next lookahead level or the sum stage; all outputs registered, one cycle latency.

---
 rtl/gi_if.sv | 27 ++
 rtl/gi.sv | 87 ++++++++
 tb/tb_gi.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gi_if.sv
// Operand/result bundle for the gi generate/propagate cell.
//   master : drives in_valid, A, B, CIN; receives the registered results
//   slave  : receives operands; drives out_valid, G, P, GG, GP, C
interface gi_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             out_valid;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] P;
  logic             GG;
  logic             GP;
  logic [WIDTH:0]   C;

  modport master (
    output in_valid, A, B, CIN,
    input  out_valid, G, P, GG, GP, C
  );

  modport slave (
    input  in_valid, A, B, CIN,
    output out_valid, G, P, GG, GP, C
  );
endinterface

// File: rtl/gi.sv
// Registered carry-lookahead generate/propagate cell for one WIDTH-bit block.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : gi_if slave -- in_valid/A/B/CIN in; out_valid/G/P/GG/GP/C out,
//           all outputs registered with one cycle of latency.
// Data outputs only load when in_valid is high, so operand values (including
// unknowns) presented while in_valid is low never reach the outputs.
module gi #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  gi_if.slave  bus
);

  // Generate reaching bit position `top` from inside bits 0..top:
  // OR over j of g[j] & p[j+1] & ... & p[top] (flattened sum of products).
  function automatic logic gen_term(input logic [WIDTH-1:0] g,
                                    input logic [WIDTH-1:0] p,
                                    input int               top);
    logic acc;
    logic prod;
    acc = 1'b0;
    for (int j = 0; j <= top; j++) begin
      prod = g[j];
      for (int k = j + 1; k <= top; k++) begin
        prod = prod & p[k];
      end
      acc = acc | prod;
    end
    return acc;
  endfunction

  // Propagate of bits 0..top: AND of p[0] .. p[top].
  function automatic logic prop_term(input logic [WIDTH-1:0] p,
                                     input int               top);
    logic prod;
    prod = 1'b1;
    for (int k = 0; k <= top; k++) begin
      prod = prod & p[k];
    end
    return prod;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             gg;
  logic             gp;

  // Per-bit terms, lookahead carries and group terms from the live operands.
  always_comb begin
    g    = bus.A & bus.B;
    p    = bus.A ^ bus.B;
    c    = '0;
    c[0] = bus.CIN;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = gen_term(g, p, i) | (prop_term(p, i) & bus.CIN);
    end
    // Group generate is the block carry-out with a zero carry-in.
    gg = gen_term(g, p, WIDTH - 1);
    gp = prop_term(p, WIDTH - 1);
  end

  // Output register stage: valid follows in_valid, data only loads on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.G         <= '0;
      bus.P         <= '0;
      bus.GG        <= 1'b0;
      bus.GP        <= 1'b0;
      bus.C         <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.G  <= g;
        bus.P  <= p;
        bus.GG <= gg;
        bus.GP <= gp;
        bus.C  <= c;
      end
    end
  end

endmodule

// File: tb/tb_gi.sv
// Self-checking bench for gi: a WIDTH=4 instance driven from a vector table
// plus directed reset/valid sequences and an arithmetic-model sweep, and a
// WIDTH=1 instance for the single-bit truth table.
module tb_gi;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gi_if #(.WIDTH(4)) bus4 ();
  gi_if #(.WIDTH(1)) bus1 ();

  gi #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  gi #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] g;
    logic [3:0] p;
    logic       gg;
    logic       gp;
    logic [4:0] c;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic ov, input logic [3:0] g,
                        input logic [3:0] p, input logic gg, input logic gp,
                        input logic [4:0] c);
    check({name, ".out_valid"}, {31'd0, bus4.out_valid}, {31'd0, ov});
    check({name, ".G"},  {28'd0, bus4.G},  {28'd0, g});
    check({name, ".P"},  {28'd0, bus4.P},  {28'd0, p});
    check({name, ".GG"}, {31'd0, bus4.GG}, {31'd0, gg});
    check({name, ".GP"}, {31'd0, bus4.GP}, {31'd0, gp});
    check({name, ".C"},  {27'd0, bus4.C},  {27'd0, c});
  endtask

  // Carry into bit i taken from the arithmetic sum of the low i bits.
  function automatic logic [4:0] ref_c(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] c;
    logic [4:0] mask;
    logic [4:0] s;
    c[0] = cin;
    for (int i = 1; i <= 4; i++) begin
      mask = (5'd1 << i) - 5'd1;
      s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {4'd0, cin};
      c[i] = s[i];
    end
    return c;
  endfunction

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    bus4.in_valid = v;
    bus4.A        = a;
    bus4.B        = b;
    bus4.CIN      = cin;
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    logic [4:0] sum;
    checks   = 0;
    failures = 0;

    //          a      b      cin   g      p      gg    gp    c
    vecs[0]  = '{4'hF, 4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 5'b11111};
    vecs[1]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 5'b00000};
    // 5 + 3 = 8: carries ripple into bits 1, 2 and 3
    vecs[2]  = '{4'h5, 4'h3, 1'b0, 4'h1, 4'h6, 1'b0, 1'b0, 5'b01110};
    vecs[3]  = '{4'hF, 4'hF, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 5'b11110};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 5'b11111};
    vecs[5]  = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00001};
    vecs[6]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00000};
    vecs[7]  = '{4'hA, 4'h5, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 5'b11111};
    vecs[8]  = '{4'h8, 4'h8, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0, 5'b10000};
    vecs[9]  = '{4'h3, 4'h1, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0, 5'b00110};
    vecs[10] = '{4'h7, 4'h9, 1'b0, 4'h1, 4'hE, 1'b1, 1'b0, 5'b11110};
    vecs[11] = '{4'h6, 4'h1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0, 5'b01111};

    rst_n         = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.A        = 4'h0;
    bus4.B        = 4'h0;
    bus4.CIN      = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.A        = 1'b0;
    bus1.B        = 1'b0;
    bus1.CIN      = 1'b0;

    // Reset held with toggling inputs: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
      bus1.in_valid = 1'b1;
      bus1.A        = 1'($urandom_range(1, 0));
      bus1.B        = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      check4("reset_hold", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00000);
      check("reset_hold.w1", {30'd0, bus1.out_valid, bus1.G}, 32'd0);
    end

    // Release with in_valid low: out_valid stays 0.
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    bus1.in_valid = 1'b0;
    rst_n         = 1'b1;
    @(posedge clk);
    #1;
    check4("release_idle", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00000);

    // Table vectors, back-to-back with in_valid held high.
    for (int i = 0; i < 12; i++) begin
      drive4(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      #1;
      check4($sformatf("vec%0d", i), 1'b1, vecs[i].g, vecs[i].p, vecs[i].gg, vecs[i].gp, vecs[i].c);
    end

    // Valid gating: changed (unknown) operands with in_valid low must not load.
    drive4(1'b1, 4'h5, 4'h3, 1'b0);
    @(posedge clk);
    #1;
    check4("gate_first", 1'b1, 4'h1, 4'h6, 1'b0, 1'b0, 5'b01110);
    drive4(1'b0, 4'hx, 4'hx, 1'bx);
    @(posedge clk);
    #1;
    check4("gate_hold", 1'b0, 4'h1, 4'h6, 1'b0, 1'b0, 5'b01110);
    drive4(1'b0, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    check4("gate_hold2", 1'b0, 4'h1, 4'h6, 1'b0, 1'b0, 5'b01110);

    // Back-to-back random operands against an arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      rc = 1'($urandom_range(1, 0));
      drive4(1'b1, ra, rb, rc);
      @(posedge clk);
      #1;
      sum = {1'b0, ra} + {1'b0, rb};
      check4($sformatf("b2b%0d", i), 1'b1, ra & rb, ra ^ rb, sum[4],
             ((ra ^ rb) == 4'hF) ? 1'b1 : 1'b0, ref_c(ra, rb, rc));
    end

    // Carry-out sweep: C[4] against the top bit of A + B + CIN.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      rc = 1'($urandom_range(1, 0));
      drive4(1'b1, ra, rb, rc);
      @(posedge clk);
      #1;
      sum = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
      check($sformatf("cout%0d", i), {31'd0, bus4.C[4]}, {31'd0, sum[4]});
    end

    // Asynchronous reset between edges clears outputs without a clock edge.
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    check4("pre_async", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 5'b11111);
    #2;
    rst_n = 1'b0;
    #1;
    check4("async_clear", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00000);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    rst_n         = 1'b1;
    @(posedge clk);
    #1;
    check4("after_release", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 5'b00000);
    drive4(1'b1, 4'h7, 4'h9, 1'b0);
    @(posedge clk);
    #1;
    check4("first_after_release", 1'b1, 4'h1, 4'hE, 1'b1, 1'b0, 5'b11110);

    // WIDTH=1 truth table: G = A&B, P = A^B, C = {G, CIN}, GG = G, GP = P.
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic       eg;
      logic       ep;
      ab = 2'(i);
      eg = ab[1] & ab[0];
      ep = ab[1] ^ ab[0];
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.A        = ab[1];
      bus1.B        = ab[0];
      bus1.CIN      = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check($sformatf("w1_ab%0d", i),
            {26'd0, bus1.out_valid, bus1.G, bus1.P, bus1.GG, bus1.GP, bus1.C[1]},
            {26'd0, 1'b1, eg, ep, eg, ep, eg});
      check($sformatf("w1_c0_%0d", i), {31'd0, bus1.C[0]}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
